// File: rtl/cc_pkg.sv
// Shared encodings and helpers for the cc_tmr_counter block.
package cc_pkg;

    localparam int CC_MODE_WRAP = 0;
    localparam int CC_MODE_SAT  = 1;

    // Width of an index selecting one of n items; never narrower than one bit.
    function automatic int cc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cc_tmr_voter.sv
// Bitwise 2-of-3 majority vote with a replica-disagreement flag.
module cc_tmr_voter #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] v,
    output logic             mis
);

    assign v   = (a & b) | (a & c) | (b & c);
    assign mis = (a != b) || (b != c);

endmodule

// File: rtl/cc_tmr_counter.sv
// N_CH up-counters with optional TMR replicas, majority vote and sticky error flags.
// Define CC_FAULT_INJ_EN to add the inj_* replica bit-flip ports.
module cc_tmr_counter
    import cc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int N_CH     = 4,
    parameter int SAT_MODE = CC_MODE_WRAP
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_CH-1:0]               enable,
    input  logic [N_CH-1:0]               clear,
    input  logic                          fp,
    input  logic                          err_clr,
`ifdef CC_FAULT_INJ_EN
    input  logic                          inj_valid,
    input  logic [cc_idx_w(N_CH)-1:0]     inj_ch,
    input  logic [1:0]                    inj_rep,
    input  logic [cc_idx_w(WIDTH)-1:0]    inj_bit,
`endif
    output logic [N_CH*WIDTH-1:0]         out,
    output logic [N_CH-1:0]               tc,
    output logic [N_CH-1:0]               err_ch,
    output logic                          err
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [N_CH-1:0][WIDTH-1:0] r0, r1, r2;
    logic [N_CH-1:0][WIDTH-1:0] r0_d, r1_d, r2_d, v, n;
    logic [N_CH-1:0]            mis, tc_d, sat_hit, sat_hit_d, err_ch_d;
    logic                       fp_q, resync, vote_on;

    // On the fp rising edge r1/r2 are stale, so r0 alone drives that cycle.
    assign resync  = fp & ~fp_q;
    assign vote_on = fp & ~fp_q;
    assign err_ch_d = (err_ch & ~{N_CH{err_clr}}) | mis;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [WIDTH-1:0] maj, m0, m1, m2;
        logic             vmis, hit;

        cc_tmr_voter #(.WIDTH(WIDTH)) u_vote (
            .a   (r0[i]),
            .b   (r1[i]),
            .c   (r2[i]),
            .v   (maj),
            .mis (vmis)
        );

        assign v[i]   = (fp && !resync) ? maj : r0[i];
        assign hit    = enable[i] && !clear[i] && (v[i] == MAX);
        assign n[i]   = clear[i]  ? '0 :
                        !enable[i] ? v[i] :
                        (SAT_MODE == CC_MODE_SAT && v[i] == MAX) ? MAX :
                        v[i] + WIDTH'(1);
        assign mis[i] = fp && !resync && vmis;

        // Saturate mode fires tc once per visit to MAX; sat_hit re-arms on leaving MAX.
        assign tc_d[i]      = hit && (SAT_MODE != CC_MODE_SAT || !sat_hit[i]);
        assign sat_hit_d[i] = (n[i] == MAX) && (sat_hit[i] || hit);

`ifdef CC_FAULT_INJ_EN
        logic [WIDTH-1:0] fm;
        assign fm = (inj_valid && inj_ch == cc_idx_w(N_CH)'(i)) ? (WIDTH'(1) << inj_bit) : '0;
        assign m0 = (inj_rep == 2'd0) ? fm : '0;
        assign m1 = (inj_rep == 2'd1) ? fm : '0;
        assign m2 = (inj_rep == 2'd2) ? fm : '0;
`else
        assign m0 = '0;
        assign m1 = '0;
        assign m2 = '0;
`endif

        // Flips land after the normal update so the next vote sees the upset.
        assign r0_d[i] = n[i] ^ m0;
        assign r1_d[i] = (fp ? n[i] : r1[i]) ^ m1;
        assign r2_d[i] = (fp ? n[i] : r2[i]) ^ m2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r0      <= '0;
            r1      <= '0;
            r2      <= '0;
            out     <= '0;
            tc      <= '0;
            sat_hit <= '0;
            err_ch  <= '0;
            err     <= 1'b0;
            fp_q    <= 1'b0;
        end else begin
            r0      <= r0_d;
            r1      <= r1_d;
            r2      <= r2_d;
            out     <= n;
            tc      <= tc_d;
            sat_hit <= sat_hit_d;
            err_ch  <= err_ch_d;
            err     <= |err_ch_d;
            fp_q    <= fp;
        end
    end

    logic unused_vote_on;
    assign unused_vote_on = vote_on;

endmodule
